// File: rtl/mccu_period_sched.sv
// -----------------------------------------------------------------------------
// mccu_period_sched
//
// Periodic budget scheduler sitting between the software register bank and the
// Maximum-Contention Control Unit (MCCU). Time is split into fixed-length
// periods. At every period boundary the MCCU enable is dropped for one cycle
// (LOAD) while the new per-core quotas are presented, so the MCCU reloads its
// counters. Quota interrupts from the MCCU become per-core stall requests that
// last until the next period boundary, and set sticky overrun flags.
//
// Ports
//   clk_i          clock
//   rstn_i         asynchronous, active-low reset
//   start_i        pulse: begin periodic operation (ignored when period_i == 0)
//   stop_i         pulse: abort and return to IDLE (wins over start_i)
//   period_i       period length in cycles
//   budget_i       per-core budget, core c at [c*DATA_WIDTH +: DATA_WIDTH]
//   mccu_irq_i     per-core quota interrupt from the MCCU
//   overrun_clr_i  per-core write-1 clear of the overrun flag
//   mccu_enable_o  MCCU enable (high only in RUN)
//   mccu_quota_o   quota presented to the MCCU (budget shadow)
//   core_stall_o   per-core stall request
//   overrun_o      sticky per-core overrun flag
//   period_done_o  one-cycle pulse in the LOAD cycle that ends a period
//   state_o        current state: IDLE=0, LOAD=1, RUN=2
//
// Interface semantics: there is no valid/ready handshake on this block. start_i,
// stop_i and overrun_clr_i are single-cycle pulses sampled on every rising edge;
// they are never back-pressured, so a pulse arriving in a state that does not
// use it is simply dropped.
// -----------------------------------------------------------------------------
module mccu_period_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_CORES      = 2,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            start_i,
  input  logic                            stop_i,
  input  logic [PERIOD_WIDTH-1:0]         period_i,
  input  logic [N_CORES*DATA_WIDTH-1:0]   budget_i,
  input  logic [N_CORES-1:0]              mccu_irq_i,
  input  logic [N_CORES-1:0]              overrun_clr_i,
  output logic                            mccu_enable_o,
  output logic [N_CORES*DATA_WIDTH-1:0]   mccu_quota_o,
  output logic [N_CORES-1:0]              core_stall_o,
  output logic [N_CORES-1:0]              overrun_o,
  output logic                            period_done_o,
  output logic [1:0]                      state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]                    state_q;
  logic [1:0]                    state_d;
  logic [PERIOD_WIDTH-1:0]       cnt_q;
  logic [PERIOD_WIDTH-1:0]       period_sh_q;
  logic [N_CORES*DATA_WIDTH-1:0] budget_sh_q;
  logic [N_CORES-1:0]            stall_q;
  logic [N_CORES-1:0]            overrun_q;
  logic                          done_q;

  // Decoded controls from the output process.
  logic                          in_run;
  logic                          enter_load;
  logic                          load_to_run;
  logic                          stay_run;
  logic [N_CORES-1:0]            irq_run;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && (period_i != '0)) state_d = S_LOAD;
        end
        S_LOAD: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (cnt_q == '0) state_d = S_LOAD;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    in_run      = (state_q == S_RUN);
    enter_load  = (state_d == S_LOAD);
    load_to_run = (state_q == S_LOAD) && (state_d == S_RUN);
    stay_run    = in_run && (state_d == S_RUN);
    // Interrupts only mean something while the MCCU is enabled.
    irq_run     = in_run ? mccu_irq_i : '0;
  end

  // ---------------------------------------------------------------------------
  // Shadows and period counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      budget_sh_q <= '0;
      period_sh_q <= '0;
      cnt_q       <= '0;
    end else begin
      if (enter_load) begin
        budget_sh_q <= budget_i;
        // A zero period would make the reload underflow; keep the previous
        // length instead. From IDLE, LOAD is only entered with a non-zero value.
        if (period_i != '0) period_sh_q <= period_i;
      end
      if (load_to_run) begin
        // Counter runs P-1 .. 0, giving exactly P RUN cycles.
        cnt_q <= period_sh_q - 1'b1;
      end else if (stay_run && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall, overrun and period-done flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_q   <= '0;
      overrun_q <= '0;
      done_q    <= 1'b0;
    end else begin
      // Stalls only persist while remaining in RUN; any exit clears them.
      stall_q   <= stay_run ? (stall_q | irq_run) : '0;
      // Set has priority over a same-cycle clear.
      overrun_q <= (overrun_q & ~overrun_clr_i) | irq_run;
      // Marks the LOAD that closes a period, never the LOAD after start.
      done_q    <= in_run && enter_load;
    end
  end

  assign mccu_enable_o = in_run;
  assign mccu_quota_o  = budget_sh_q;
  assign core_stall_o  = stall_q;
  assign overrun_o     = overrun_q;
  assign period_done_o = done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mccu_period_sched.sv
// -----------------------------------------------------------------------------
// tb_mccu_period_sched
//
// Directed + randomized bench for mccu_period_sched. A period-level reference
// model (mode, cycles remaining in RUN, shadows, flags) predicts every output
// after each clock edge.
// -----------------------------------------------------------------------------
module tb_mccu_period_sched;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int PW = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_i = 1'b0;
  logic rstn_i;
  always #5 clk_i = ~clk_i;

  logic               start_i;
  logic               stop_i;
  logic [PW-1:0]      period_i;
  logic [NC*DW-1:0]   budget_i;
  logic [NC-1:0]      mccu_irq_i;
  logic [NC-1:0]      overrun_clr_i;
  logic               mccu_enable_o;
  logic [NC*DW-1:0]   mccu_quota_o;
  logic [NC-1:0]      core_stall_o;
  logic [NC-1:0]      overrun_o;
  logic               period_done_o;
  logic [1:0]         state_o;

  mccu_period_sched #(
    .DATA_WIDTH   (DW),
    .N_CORES      (NC),
    .PERIOD_WIDTH (PW)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .period_i      (period_i),
    .budget_i      (budget_i),
    .mccu_irq_i    (mccu_irq_i),
    .overrun_clr_i (overrun_clr_i),
    .mccu_enable_o (mccu_enable_o),
    .mccu_quota_o  (mccu_quota_o),
    .core_stall_o  (core_stall_o),
    .overrun_o     (overrun_o),
    .period_done_o (period_done_o),
    .state_o       (state_o)
  );

  int checks = 0;
  int errors = 0;

  // Currently programmed register-bank values.
  logic [PW-1:0]    cur_per;
  logic [NC*DW-1:0] cur_bud;

  // ---------------------------------------------------------------------------
  // Reference model: mode 0=IDLE 1=LOAD 2=RUN, plus RUN cycles left.
  // ---------------------------------------------------------------------------
  int               m_state;
  int               m_left;
  logic [NC*DW-1:0] m_bud;
  logic [PW-1:0]    m_per;
  logic [NC-1:0]    m_stall;
  logic [NC-1:0]    m_ovr;
  logic             m_done;

  task automatic model_reset();
    m_state = 0; m_left = 0; m_bud = '0; m_per = '0;
    m_stall = '0; m_ovr = '0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic sp,
                            input logic [NC-1:0] irq, input logic [NC-1:0] clr);
    int            ns;
    logic [NC-1:0] irq_s;
    irq_s = (m_state == 2) ? irq : '0;
    if (sp)                ns = 0;
    else if (m_state == 0) ns = (st && cur_per != 0) ? 1 : 0;
    else if (m_state == 1) ns = 2;
    else                   ns = (m_left == 1) ? 1 : 2;
    m_done  = (m_state == 2) && (ns == 1);
    m_ovr   = (m_ovr & ~clr) | irq_s;
    m_stall = (m_state == 2 && ns == 2) ? (m_stall | irq_s) : '0;
    if (ns == 1) begin
      m_bud = cur_bud;
      m_per = cur_per;
    end
    if (ns == 2) m_left = (m_state == 1) ? int'(m_per) : m_left - 1;
    m_state = ns;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard comparisons
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] es;
    es = m_state[1:0];
    chk("state",  64'(state_o), 64'(es));
    chk("enable", 64'(mccu_enable_o), 64'(m_state == 2));
    chk("quota",  mccu_quota_o, m_bud);
    chk("stall",  64'(core_stall_o), 64'(m_stall));
    chk("overrun", 64'(overrun_o), 64'(m_ovr));
    chk("done",   64'(period_done_o), 64'(m_done));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, advance model, check after the edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic st, input logic sp,
                      input logic [NC-1:0] irq, input logic [NC-1:0] clr);
    start_i = st; stop_i = sp; mccu_irq_i = irq; overrun_clr_i = clr;
    period_i = cur_per; budget_i = cur_bud;
    @(posedge clk_i);
    model_step(st, sp, irq, clr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rstn_i = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; mccu_irq_i = '0; overrun_clr_i = '0;
    period_i = '0; budget_i = '0;
    cur_per = '0; cur_bud = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Basic periodic operation: period 4, core1 = 3, core0 = 10.
    cur_per = 4;
    cur_bud = {32'd3, 32'd10};
    step(1'b1, 1'b0, '0, '0);            // -> LOAD
    step(1'b0, 1'b0, '0, '0);            // RUN cycle 1
    step(1'b0, 1'b0, 2'b10, '0);         // RUN cycle 2, irq core 1
    idle(10);

    // Mid-period reprogramming takes effect at the next LOAD.
    step(1'b0, 1'b0, '0, '0);
    cur_bud = {32'd3, 32'd7};
    cur_per = 2;
    idle(10);

    // stop and start together: stop wins.
    step(1'b1, 1'b1, '0, '0);
    idle(2);
    cur_per = 0;
    step(1'b1, 1'b0, '0, '0);            // start with zero period is ignored
    idle(2);

    // Clear overrun, then set and clear in the same cycle: set wins.
    step(1'b0, 1'b0, '0, 2'b11);
    cur_per = 3;
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 2'b10, 2'b10);
    idle(2);
    step(1'b0, 1'b0, '0, 2'b10);
    idle(3);

    // Period 1: back-to-back RUN/LOAD.
    cur_per = 1;
    step(1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic          st;
      logic          sp;
      logic [NC-1:0] irq;
      logic [NC-1:0] clr;
      st  = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 29) == 0);
      irq = ($urandom_range(0, 5) == 0) ? NC'($urandom_range(1, 3)) : '0;
      clr = ($urandom_range(0, 7) == 0) ? NC'($urandom_range(1, 3)) : '0;
      if ($urandom_range(0, 11) == 0) cur_bud = {$urandom, $urandom};
      if ($urandom_range(0, 11) == 0)
        cur_per = (m_state == 0) ? PW'($urandom_range(0, 5)) : PW'($urandom_range(1, 5));
      step(st, sp, irq, clr);
    end

    // Asynchronous reset in the middle of RUN.
    step(1'b0, 1'b1, '0, '0);
    cur_per = 5;
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 2'b01, '0);
    step(1'b0, 1'b0, '0, '0);
    start_i = 1'b0; stop_i = 1'b0; mccu_irq_i = '0; overrun_clr_i = '0;
    #2;
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk_i);
    rstn_i = 1'b1;
    idle(2);
    step(1'b1, 1'b0, '0, '0);
    idle(7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mccu_period_sched.md
Name: mccu_period_sched

Overview:
- Periodic budget scheduler that sequences the Maximum-Contention Control Unit (MCCU).
- Splits time into fixed-length periods and reloads each core's contention quota at every period boundary by dropping the MCCU enable for one cycle while presenting the new quotas.
- Turns MCCU quota interrupts into per-core stall requests that last until the next period, plus sticky software-visible overrun flags.
- Sits between the software-programmed register bank and the MCCU instance.

Parameters:
- DATA_WIDTH, 32, width of each core quota/budget.
- N_CORES, 2, number of monitored cores.
- PERIOD_WIDTH, 32, width of the period length register.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous, active-low reset.
- start_i  in  1  pulse: begin periodic operation.
- stop_i  in  1  pulse: abort operation and return to IDLE.
- period_i  in  PERIOD_WIDTH  period length in cycles; 0 is illegal.
- budget_i  in  N_CORES*DATA_WIDTH  per-core budget; core c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- mccu_irq_i  in  N_CORES  quota interrupt from the MCCU, one bit per core.
- overrun_clr_i  in  N_CORES  per-core write-1 pulse that clears the matching overrun flag.
- mccu_enable_o  out  1  enable to the MCCU.
- mccu_quota_o  out  N_CORES*DATA_WIDTH  quota value presented to the MCCU.
- core_stall_o  out  N_CORES  per-core stall request.
- overrun_o  out  N_CORES  sticky flag: the core exhausted its quota in some period.
- period_done_o  out  1  one-cycle pulse at each period boundary.
- state_o  out  2  current state: IDLE=0, LOAD=1, RUN=2.

Behaviour:
- Reset: state IDLE; every output is 0; period counter, budget shadow and period shadow are 0.
- IDLE:
  - mccu_enable_o is 0.
  - start_i=1 with period_i!=0: go to LOAD next edge.
  - start_i=1 with period_i==0: ignored, stay in IDLE.
- LOAD (exactly 1 cycle):
  - mccu_enable_o is 0.
  - mccu_quota_o is driven from the budget shadow; the MCCU captures it at the end of this cycle.
  - core_stall_o is 0.
  - Always go to RUN next edge, loading the counter with period shadow - 1.
- Shadow capture:
  - budget_i and period_i are captured into the shadows on every edge that enters LOAD, whether from IDLE or from RUN.
  - Changes to budget_i or period_i mid-period take effect at the next period.
- RUN:
  - mccu_enable_o is 1; mccu_quota_o holds the shadow value.
  - The counter decrements each cycle. When it reads 0, go to LOAD. RUN therefore lasts exactly period shadow cycles.
- period_done_o: asserted for 1 cycle, in the first cycle of each LOAD entered from RUN. It is not asserted on a LOAD entered from IDLE.
- Stall and overrun:
  - mccu_irq_i is sampled only in RUN; it is ignored in IDLE and LOAD.
  - If mccu_irq_i[c]=1 in RUN: core_stall_o[c] is set next edge and stays set for the rest of RUN.
  - core_stall_o[c] is cleared on entry to LOAD or IDLE.
  - If mccu_irq_i[c]=1 in RUN: overrun_o[c] is set next edge.
  - overrun_o[c] is cleared only by overrun_clr_i[c]. If set and clear occur in the same cycle, set wins.
  - overrun_o survives stop_i and period boundaries.
- stop_i: from any state, go to IDLE next edge.
  - mccu_enable_o=0 and core_stall_o=0 from that edge.
  - mccu_quota_o holds its last value.
- Simultaneous start_i and stop_i: stop_i wins.
- start_i while in LOAD or RUN: ignored.
- Reset mid-period: immediate return to reset values, including overrun_o.
- Width rules:
  - The counter is PERIOD_WIDTH wide and never wraps; it is reloaded before it could go below 0.
  - period shadow = 1 gives back-to-back pattern RUN(1 cycle), LOAD(1 cycle).
- Latency: start_i sampled at edge t gives LOAD in cycle t+1 and mccu_enable_o=1 from edge t+2.

Test Plan:
- Reset, then start_i with period_i=4, budget={core1:3, core0:10}:
  - state_o sequence is IDLE, LOAD, RUN×4, LOAD, RUN×4, …
  - mccu_enable_o is 0 only in LOAD cycles.
  - period_done_o pulses once per LOAD entered from RUN.
- During RUN, drive mccu_irq_i[1]=1 for one cycle at RUN cycle 2:
  - core_stall_o[1]=1 from the next edge until the LOAD boundary, then 0.
  - overrun_o[1]=1 and stays 1.
  - core 0 outputs are unaffected.
- Change budget_i core0 to 7 and period_i to 2 at mid-period: mccu_quota_o and the RUN length change only after the next LOAD.
- Assert stop_i and start_i in the same cycle during RUN:
  - state IDLE next edge; enable 0; stalls 0.
  - A later start_i with period_i=0 leaves state IDLE.
- Pulse overrun_clr_i[1] in the same cycle an irq sets overrun_o[1]: the flag stays 1. A later lone clear pulse gives 0.
- Deassert rstn_i asynchronously mid-RUN: all outputs go to 0 immediately, without waiting for a clock edge.
